// File: rtl/dense_argmax_pkg.sv
// Shared types and helpers for the dense-layer readout blocks.
// Holds the scan FSM encoding, the default score width and the index-width helper.
package dense_argmax_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int WIDTH_DEF = 8;
  localparam int SCORE_W   = 4 * WIDTH_DEF;

  // Index width for n entries, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dense_argmax.sv
// Argmax over a snapshot of dense-layer scores: one score compared per cycle,
// result held behind a valid/ack handshake; start edges outside IDLE are dropped.
module dense_argmax
  import dense_argmax_pkg::*;
#(
  parameter int CLASS_NB = 10,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int IDX_W    = idx_w(CLASS_NB)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic signed [4*WIDTH-1:0] scores [CLASS_NB],
  input  logic                   ack,
  output logic [IDX_W-1:0]       class_out,
  output logic signed [4*WIDTH-1:0] max_score,
  output logic                   valid,
  output logic                   busy
);

  localparam int SW = 4 * WIDTH;
  localparam bit SINGLE = (CLASS_NB == 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CLASS_NB - 1);

  state_e state_q, state_d;
  logic   start_q;
  logic   trig;

  logic signed [SW-1:0] snap_q [CLASS_NB];
  logic signed [SW-1:0] best_val_q, best_val_d;
  logic [IDX_W-1:0]     best_idx_q, best_idx_d;
  logic [IDX_W-1:0]     idx_q;
  logic signed [SW-1:0] cand;
  logic [IDX_W-1:0]     class_q;
  logic signed [SW-1:0] max_q;

  assign trig = start && !start_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (trig) state_d = SINGLE ? HOLD : SCAN;
      SCAN: if (idx_q == LAST_IDX) state_d = HOLD;
      HOLD: if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    valid = 1'b0;
    busy  = 1'b0;
    case (state_q)
      SCAN: busy = 1'b1;
      HOLD: begin
        busy  = 1'b1;
        valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    cand       = snap_q[idx_q];
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    if (cand > best_val_q) begin
      best_val_d = cand;
      best_idx_d = idx_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CLASS_NB; i++) snap_q[i] <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
      idx_q      <= '0;
      class_q    <= '0;
      max_q      <= '0;
    end else begin
      if (state_q == IDLE && trig) begin
        for (int i = 0; i < CLASS_NB; i++) snap_q[i] <= scores[i];
        best_val_q <= scores[0];
        best_idx_q <= '0;
        idx_q      <= SINGLE ? '0 : IDX_W'(1);
        if (SINGLE) begin
          class_q <= '0;
          max_q   <= scores[0];
        end
      end else if (state_q == SCAN) begin
        best_val_q <= best_val_d;
        best_idx_q <= best_idx_d;
        idx_q      <= idx_q + IDX_W'(1);
        if (state_d == HOLD) begin
          class_q <= best_idx_d;
          max_q   <= best_val_d;
        end
      end
    end
  end

  assign class_out = class_q;
  assign max_score = max_q;

endmodule
